// File: rtl/paula_audio_pkg.sv
// Shared definitions for the Paula-style four-channel audio mixer:
// sequencer states, volume full-scale value and datapath widths.
package paula_audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CH0,
    CH1,
    CH2,
    CH3,
    DONE
  } mix_state_t;

  localparam int unsigned VOL_MAX = 64;
  localparam int unsigned PROD_W  = 14;
  localparam int unsigned SUM_W   = 15;

  function automatic logic [1:0] chan_of(input mix_state_t s);
    case (s)
      CH1:     return 2'd1;
      CH2:     return 2'd2;
      CH3:     return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/paula_audio_volume.sv
// Signed 8-bit sample times unsigned 6-bit volume, 14-bit signed product.
module paula_audio_volume
  import paula_audio_pkg::*;
(
  input  logic [7:0]        sample,
  input  logic [5:0]        vol,
  output logic [PROD_W-1:0] product
);

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] vol_ext;

  assign sample_ext = {{(PROD_W-8){sample[7]}}, sample};
  assign vol_ext    = {{(PROD_W-6){1'b0}}, vol};
  // |result| <= 128*63, so truncation to PROD_W bits is exact
  assign product    = sample_ext * vol_ext;

endmodule

// File: rtl/paula_audio_mixer.sv
// Four-channel audio mixer: snapshots inputs on strb, scales each channel
// through one shared multiplier and sums into left (0+3) / right (1+2) outputs.
module paula_audio_mixer
  import paula_audio_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk7_en,
  input  logic        strb,
  input  logic [7:0]  sample0,
  input  logic [7:0]  sample1,
  input  logic [7:0]  sample2,
  input  logic [7:0]  sample3,
  input  logic [6:0]  vol0,
  input  logic [6:0]  vol1,
  input  logic [6:0]  vol2,
  input  logic [6:0]  vol3,
  input  logic [3:0]  mute,
  output logic [14:0] ldata,
  output logic [14:0] rdata,
  output logic        valid,
  output logic        busy,
  output logic        overrun
);

  mix_state_t state, state_next;

  logic [7:0]  smp      [4];
  logic [6:0]  vol_snap [4];
  logic [3:0]  mute_snap;

  logic signed [SUM_W-1:0] acc_l, acc_r;

  logic [1:0]        ch;
  logic [7:0]        sel_sample;
  logic [6:0]        sel_vol;
  logic              sel_mute;
  logic [PROD_W-1:0] mult_prod;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  prod_ext;

  assign ch         = chan_of(state);
  assign sel_sample = smp[ch];
  assign sel_vol    = vol_snap[ch];
  assign sel_mute   = mute_snap[ch];
  assign busy       = (state != IDLE);

  paula_audio_volume u_volume (
    .sample  (sel_sample),
    .vol     (sel_vol[5:0]),
    .product (mult_prod)
  );

  // Full scale (and above) bypasses the 6-bit multiplier as a plain shift
  always_comb begin
    prod = mult_prod;
    if (sel_vol >= 7'(VOL_MAX)) prod = {sel_sample, 6'b0};
    if (sel_mute) prod = '0;
  end

  assign prod_ext = {prod[PROD_W-1], prod};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else if (clk7_en) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (strb) state_next = CH0;
      CH0:     state_next = CH1;
      CH1:     state_next = CH2;
      CH2:     state_next = CH3;
      CH3:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pulses clear on every clk so they stay one clk wide regardless of clk7_en
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp       <= '{default: '0};
      vol_snap  <= '{default: '0};
      mute_snap <= '0;
      acc_l     <= '0;
      acc_r     <= '0;
      ldata     <= '0;
      rdata     <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= 1'b0;
      if (clk7_en) begin
        case (state)
          IDLE: if (strb) begin
            smp[0]      <= sample0;
            smp[1]      <= sample1;
            smp[2]      <= sample2;
            smp[3]      <= sample3;
            vol_snap[0] <= vol0;
            vol_snap[1] <= vol1;
            vol_snap[2] <= vol2;
            vol_snap[3] <= vol3;
            mute_snap   <= mute;
            acc_l       <= '0;
            acc_r       <= '0;
          end
          CH0, CH3: acc_l <= acc_l + prod_ext;
          CH1, CH2: acc_r <= acc_r + prod_ext;
          DONE: begin
            ldata <= acc_l;
            rdata <= acc_r;
            valid <= 1'b1;
          end
          default: ;
        endcase
        if (strb && state != IDLE) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_paula_audio_mixer.sv
// Directed-vector bench for paula_audio_mixer with hand-computed mix results.
module tb_paula_audio_mixer;

  logic        clk;
  logic        reset_n;
  logic        clk7_en;
  logic        strb;
  logic [7:0]  sample0, sample1, sample2, sample3;
  logic [6:0]  vol0, vol1, vol2, vol3;
  logic [3:0]  mute;
  logic [14:0] ldata, rdata;
  logic        valid, busy, overrun;

  int total = 0;
  int bad   = 0;
  int div   = 1;
  int phase = 0;
  bit en_was;

  paula_audio_mixer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk7_en (clk7_en),
    .strb    (strb),
    .sample0 (sample0),
    .sample1 (sample1),
    .sample2 (sample2),
    .sample3 (sample3),
    .vol0    (vol0),
    .vol1    (vol1),
    .vol2    (vol2),
    .vol3    (vol3),
    .mute    (mute),
    .ldata   (ldata),
    .rdata   (rdata),
    .valid   (valid),
    .busy    (busy),
    .overrun (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // One clk cycle; clk7_en follows a 1-in-div pattern; returns 1 ns after the edge
  task automatic tick();
    clk7_en = (phase == 0);
    @(posedge clk);
    en_was = clk7_en;
    phase  = (phase + 1) % div;
    #1;
  endtask

  task automatic set_inputs(input logic [7:0] s0, s1, s2, s3,
                            input logic [6:0] v0, v1, v2, v3,
                            input logic [3:0] m);
    sample0 = s0; sample1 = s1; sample2 = s2; sample3 = s3;
    vol0 = v0; vol1 = v1; vol2 = v2; vol3 = v3;
    mute = m;
  endtask

  task automatic do_mix(input string tag, input logic [14:0] el, input logic [14:0] er);
    int edges;
    int guard;
    bit seen;
    strb  = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!en_was && guard < 20);
    strb  = 1'b0;
    edges = 1;
    // scramble live inputs: result must come from the snapshot
    set_inputs(8'h7f, 8'h7f, 8'h81, 8'h33, 7'd64, 7'd64, 7'd64, 7'd64, 4'b0000);
    chk({tag, "_busy"}, 15'(busy), 15'd1);
    seen  = 1'b0;
    guard = 0;
    while (!seen && guard < 200) begin
      tick();
      guard++;
      if (en_was) edges++;
      if (valid) seen = 1'b1;
    end
    chk({tag, "_valid_seen"}, 15'(seen), 15'd1);
    chk({tag, "_latency"}, 15'(edges), 15'd6);
    chk({tag, "_ldata"}, ldata, el);
    chk({tag, "_rdata"}, rdata, er);
    chk({tag, "_busy_done"}, 15'(busy), 15'd0);
    tick();
    chk({tag, "_valid_width"}, 15'(valid), 15'd0);
    chk({tag, "_ldata_hold"}, ldata, el);
  endtask

  initial begin
    int vcount;
    reset_n = 1'b0;
    clk7_en = 1'b1;
    strb    = 1'b0;
    set_inputs(8'h00, 8'h00, 8'h00, 8'h00, 7'd0, 7'd0, 7'd0, 7'd0, 4'b0000);
    #2;
    chk("rst_ldata", ldata, 15'd0);
    chk("rst_rdata", rdata, 15'd0);
    chk("rst_valid", 15'(valid), 15'd0);
    chk("rst_busy", 15'(busy), 15'd0);
    chk("rst_overrun", 15'(overrun), 15'd0);
    repeat (2) tick();
    reset_n = 1'b1;

    // full scale: L = 127*64 - 64 = 8064, R = -8192 + 4096 = -4096
    set_inputs(8'd127, 8'h80, 8'd64, 8'hff, 7'd64, 7'd64, 7'd64, 7'd64, 4'b0000);
    do_mix("full", 15'd8064, 15'(-4096));

    // vol above full scale clamps: -128*64
    set_inputs(8'h80, 8'd127, 8'd127, 8'd127, 7'd100, 7'd0, 7'd0, 7'd0, 4'b0000);
    do_mix("clamp", 15'(-8192), 15'd0);

    set_inputs(8'd127, 8'h80, 8'd64, 8'hff, 7'd64, 7'd64, 7'd64, 7'd64, 4'b1001);
    do_mix("mute", 15'd0, 15'(-4096));

    // 10*1 - 40*5 = -190 ; -20*63 + 30*32 = -300
    set_inputs(8'd10, 8'hec, 8'd30, 8'hd8, 7'd1, 7'd63, 7'd32, 7'd5, 4'b0000);
    do_mix("midvol", 15'(-190), 15'(-300));

    // 127*63 - 128*63 = -63 ; -128*64 twice = -16384
    set_inputs(8'd127, 8'h80, 8'h80, 8'h80, 7'd63, 7'd127, 7'd64, 7'd63, 4'b0000);
    do_mix("extreme", 15'(-63), 15'(-16384));

    // strb repeated while in CH2
    set_inputs(8'd127, 8'h80, 8'd64, 8'hff, 7'd64, 7'd64, 7'd64, 7'd64, 4'b0000);
    strb = 1'b1;
    tick();
    strb = 1'b0;
    tick();
    tick();
    set_inputs(8'd1, 8'd1, 8'd1, 8'd1, 7'd1, 7'd1, 7'd1, 7'd1, 4'b0000);
    strb = 1'b1;
    tick();
    strb = 1'b0;
    chk("ovr_pulse", 15'(overrun), 15'd1);
    tick();
    chk("ovr_width", 15'(overrun), 15'd0);
    chk("ovr_no_early_valid", 15'(valid), 15'd0);
    chk("ovr_ldata_stable", ldata, 15'(-63));
    tick();
    chk("ovr_valid", 15'(valid), 15'd1);
    chk("ovr_ldata", ldata, 15'd8064);
    chk("ovr_rdata", rdata, 15'(-4096));
    vcount = 0;
    repeat (8) begin
      tick();
      if (valid) vcount++;
    end
    chk("ovr_single_valid", 15'(vcount), 15'd0);
    chk("ovr_idle", 15'(busy), 15'd0);

    // reset during CH1 aborts the mix
    set_inputs(8'd10, 8'hec, 8'd30, 8'hd8, 7'd1, 7'd63, 7'd32, 7'd5, 4'b0000);
    strb = 1'b1;
    tick();
    strb = 1'b0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("abort_ldata", ldata, 15'd0);
    chk("abort_rdata", rdata, 15'd0);
    chk("abort_busy", 15'(busy), 15'd0);
    tick();
    tick();
    reset_n = 1'b1;
    vcount = 0;
    repeat (10) begin
      tick();
      if (valid) vcount++;
    end
    chk("abort_no_valid", 15'(vcount), 15'd0);
    do_mix("after_abort", 15'(-190), 15'(-300));

    // strb on the first edge after reset release is accepted
    #2 reset_n = 1'b0;
    set_inputs(8'd127, 8'h80, 8'd64, 8'hff, 7'd64, 7'd64, 7'd64, 7'd64, 4'b0000);
    #2 reset_n = 1'b1;
    do_mix("rel_strb", 15'd8064, 15'(-4096));

    // 1-in-4 clock enable
    div   = 4;
    phase = 0;
    set_inputs(8'd127, 8'h80, 8'd64, 8'hff, 7'd64, 7'd64, 7'd64, 7'd64, 4'b0000);
    do_mix("en4_full", 15'd8064, 15'(-4096));
    set_inputs(8'd10, 8'hec, 8'd30, 8'hd8, 7'd1, 7'd63, 7'd32, 7'd5, 4'b0000);
    do_mix("en4_midvol", 15'(-190), 15'(-300));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
